lzrw_token_sequencer: RTL

Parametrised token sequencer between the LZRW1 compressor's output buffers and the decompressor. Per block, it reads control bits and compressed bytes through two synchronous read ports. It assembles literal (1-byte) or copy (2-byte) tokens and presents them on a valid/ready stream. It supersedes the fixed busy-gated hand-off with backpressure, multi-block restart, correct control-bit indexing and overrun detection.

---
 rtl/lzrw_pkg.sv | 28 ++
 rtl/lzrw_seq_stats.sv | 52 +++++
 rtl/lzrw_token_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lzrw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lzrw_pkg
// Description : Shared types and constants for the LZRW1 token sequencer:
//               sequencer state encoding, token-type codes and the literal
//               token high-byte filler.
// Revision    : 1.0 - initial release
// ============================================================================
package lzrw_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAP0    = 3'd2,
        S_CAP1    = 3'd3,
        S_PRESENT = 3'd4,
        S_FINISH  = 3'd5
    } seq_state_t;

    // Control-bit meaning
    localparam logic TOKEN_LITERAL = 1'b0;
    localparam logic TOKEN_COPY    = 1'b1;

    // High byte of a literal token on tok_data
    localparam logic [7:0] LIT_HI_BYTE = 8'h00;

endpackage
`default_nettype wire

// File: rtl/lzrw_seq_stats.sv
`default_nettype none
// ============================================================================
// Module      : lzrw_seq_stats
// Description : Per-block literal/copy token counters for the token
//               sequencer. Cleared on an accepted start, incremented on each
//               token handshake of the matching type, held otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module lzrw_seq_stats #(
    parameter int CNT_W = 13
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             lit_inc_i,
    input  logic             copy_inc_i,
    output logic [CNT_W-1:0] stat_literals_o,
    output logic [CNT_W-1:0] stat_copies_o
);

    logic [CNT_W-1:0] lit_q, lit_d;
    logic [CNT_W-1:0] copy_q, copy_d;

    // Next-count: clear wins over increment
    always_comb begin
        lit_d  = lit_q;
        copy_d = copy_q;
        if (clear_i) begin
            lit_d  = '0;
            copy_d = '0;
        end else begin
            if (lit_inc_i)  lit_d  = lit_q + CNT_W'(1);
            if (copy_inc_i) copy_d = copy_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lit_q  <= '0;
            copy_q <= '0;
        end else begin
            lit_q  <= lit_d;
            copy_q <= copy_d;
        end
    end

    assign stat_literals_o = lit_q;
    assign stat_copies_o   = copy_q;

endmodule
`default_nettype wire

// File: rtl/lzrw_token_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lzrw_token_sequencer
// Description : Reads LZRW1 control bits and compressed bytes through two
//               synchronous read ports and presents literal (1-byte) or copy
//               (2-byte) tokens on a valid/ready stream, one block per start.
//               Optional macro LZRW_SEQ_STATS_EN adds per-block literal/copy
//               counters (stat_literals_o / stat_copies_o).
// Revision    : 1.0 - initial release
// ============================================================================
module lzrw_token_sequencer
    import lzrw_pkg::*;
#(
    parameter int DEPTH      = 4096,
    parameter int CTRL_DEPTH = 4096,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int CNT_W      = $clog2(CTRL_DEPTH + 1),
    // Derived control-port address width; leave at default
    parameter int CTRL_AW    = $clog2(CTRL_DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   token_count_i,
    input  logic [ADDR_W:0]    byte_count_i,
    output logic               ctrl_rd_en_o,
    output logic [CTRL_AW-1:0] ctrl_addr_o,
    input  logic               ctrl_rd_bit_i,
    output logic               mem_rd_en_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic [7:0]         mem_rd_data_i,
    output logic               tok_valid_o,
    input  logic               tok_ready_i,
    output logic [15:0]        tok_data_o,
    output logic               tok_is_copy_o,
    output logic               tok_last_o,
    output logic               busy_o,
    output logic               done_o,
`ifdef LZRW_SEQ_STATS_EN
    output logic [CNT_W-1:0]   stat_literals_o,
    output logic [CNT_W-1:0]   stat_copies_o,
`endif
    output logic               error_o
);

    localparam logic [CNT_W-1:0] TOK_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]  BYTE_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]  BYTE_TWO = (ADDR_W + 1)'(2);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] tok_cnt_q, tok_cnt_d;
    logic [CNT_W-1:0] tok_ptr_q, tok_ptr_d;
    logic [ADDR_W:0]  byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]  data_ptr_q, data_ptr_d;
    logic [15:0]      tok_data_q, tok_data_d;
    logic             tok_copy_q, tok_copy_d;
    logic             error_q, error_d;

    logic [ADDR_W:0]  w_data_ptr_inc;
    logic             w_have_b0;
    logic             w_have_b1;
    logic             w_is_last;
    logic             w_byte_mismatch;

    // Byte reads are only issued while the address is inside the block
    assign w_data_ptr_inc  = data_ptr_q + BYTE_ONE;
    assign w_have_b0       = (data_ptr_q < byte_cnt_q);
    assign w_have_b1       = (w_data_ptr_inc < byte_cnt_q);
    assign w_is_last       = (tok_ptr_q == (tok_cnt_q - TOK_ONE));
    assign w_byte_mismatch = (data_ptr_q != byte_cnt_q);

    assign busy_o  = (state_q != S_IDLE);
    // Mismatch is folded in combinationally so error is valid with done
    assign error_o = error_q | ((state_q == S_FINISH) & w_byte_mismatch);

    // Next-state, datapath updates and per-state outputs
    always_comb begin
        state_d       = state_q;
        tok_cnt_d     = tok_cnt_q;
        tok_ptr_d     = tok_ptr_q;
        byte_cnt_d    = byte_cnt_q;
        data_ptr_d    = data_ptr_q;
        tok_data_d    = tok_data_q;
        tok_copy_d    = tok_copy_q;
        error_d       = error_q;
        ctrl_rd_en_o  = 1'b0;
        ctrl_addr_o   = '0;
        mem_rd_en_o   = 1'b0;
        mem_addr_o    = '0;
        tok_valid_o   = 1'b0;
        tok_data_o    = '0;
        tok_is_copy_o = 1'b0;
        tok_last_o    = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    tok_cnt_d  = token_count_i;
                    byte_cnt_d = byte_count_i;
                    tok_ptr_d  = '0;
                    data_ptr_d = '0;
                    error_d    = 1'b0;
                    state_d    = (token_count_i == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                ctrl_rd_en_o = 1'b1;
                ctrl_addr_o  = tok_ptr_q[CTRL_AW-1:0];
                mem_rd_en_o  = w_have_b0;
                mem_addr_o   = data_ptr_q[ADDR_W-1:0];
                state_d      = S_CAP0;
            end
            S_CAP0: begin
                tok_copy_d = ctrl_rd_bit_i;
                if (!w_have_b0) begin
                    // No byte left even for a literal: abandon the block
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else if (ctrl_rd_bit_i == TOKEN_LITERAL) begin
                    tok_data_d = {LIT_HI_BYTE, mem_rd_data_i};
                    data_ptr_d = w_data_ptr_inc;
                    state_d    = S_PRESENT;
                end else if (w_have_b1) begin
                    tok_data_d  = {mem_rd_data_i, 8'h00};
                    mem_rd_en_o = 1'b1;
                    mem_addr_o  = w_data_ptr_inc[ADDR_W-1:0];
                    state_d     = S_CAP1;
                end else begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_CAP1: begin
                tok_data_d = {tok_data_q[15:8], mem_rd_data_i};
                data_ptr_d = data_ptr_q + BYTE_TWO;
                state_d    = S_PRESENT;
            end
            S_PRESENT: begin
                tok_valid_o   = 1'b1;
                tok_data_o    = tok_data_q;
                tok_is_copy_o = tok_copy_q;
                tok_last_o    = w_is_last;
                if (tok_ready_i) begin
                    tok_ptr_d = tok_ptr_q + TOK_ONE;
                    state_d   = w_is_last ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: begin
                done_o = 1'b1;
                if (w_byte_mismatch) error_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            tok_cnt_q  <= '0;
            tok_ptr_q  <= '0;
            byte_cnt_q <= '0;
            data_ptr_q <= '0;
            tok_data_q <= '0;
            tok_copy_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tok_cnt_q  <= tok_cnt_d;
            tok_ptr_q  <= tok_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            data_ptr_q <= data_ptr_d;
            tok_data_q <= tok_data_d;
            tok_copy_q <= tok_copy_d;
            error_q    <= error_d;
        end
    end

`ifdef LZRW_SEQ_STATS_EN
    logic w_start_acc;
    logic w_tok_hs;

    assign w_start_acc = (state_q == S_IDLE) & start_i;
    assign w_tok_hs    = tok_valid_o & tok_ready_i;

    lzrw_seq_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clear_i         (w_start_acc),
        .lit_inc_i       (w_tok_hs & (tok_copy_q == TOKEN_LITERAL)),
        .copy_inc_i      (w_tok_hs & (tok_copy_q == TOKEN_COPY)),
        .stat_literals_o (stat_literals_o),
        .stat_copies_o   (stat_copies_o)
    );
`endif

endmodule
`default_nettype wire
